// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, slice operation codes and serial FSM states
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/bit_alu.sv
// bit_alu: 1-bit MIPS ALU slice with optional operand inversion and less passthrough
module bit_alu
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carry_in,
  input  logic       less,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic [1:0] operation,
  output logic       result,
  output logic       carry_out
);
  logic aa, bb, sum;
  // invert operands, form full-adder sum/carry, then select by operation
  always_comb begin
    aa = a ^ a_invert;
    bb = b ^ b_invert;
    sum = aa ^ bb ^ carry_in;
    carry_out = (aa & bb) | (aa & carry_in) | (bb & carry_in);
    result = operation == OP_AND ? aa & bb :
             operation == OP_OR  ? aa | bb :
             operation == OP_ADD ? sum : less;
  end
endmodule

// File: rtl/serial_alu.sv
// serial_alu: bit-serial MIPS ALU running one bit_alu slice over WIDTH cycles
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);
  localparam int IW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, result_q, result_d, sh_next, fin;
  logic [3:0] ctrl_q, ctrl_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d, cout_q, cout_d;
  logic s_res, s_cout, ovf_bit;
  logic [1:0] s_op;

  assign s_op = ctrl_q[1:0] == OP_SLT ? OP_ADD : ctrl_q[1:0];

  bit_alu u_slice (
    .a(a_q[0]), .b(b_q[0]), .carry_in(carry_q), .less(1'b0),
    .a_invert(ctrl_q[3]), .b_invert(ctrl_q[2]), .operation(s_op),
    .result(s_res), .carry_out(s_cout)
  );

  // next-state: latch operands on start, shift one bit per RUN cycle, finalize flags on the last bit
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sh_d = sh_q;
    ctrl_d = ctrl_q;
    idx_d = idx_q;
    carry_d = carry_q;
    result_d = result_q;
    zero_d = zero_q;
    ovf_d = ovf_q;
    cout_d = cout_q;
    sh_next = (sh_q >> 1) | (WIDTH'(s_res) << (WIDTH - 1));
    ovf_bit = carry_q ^ s_cout;
    fin = ctrl_q[1:0] == OP_SLT ? WIDTH'(s_res ^ ovf_bit) : sh_next;
    if (start && state_q != RUN) begin
      a_d = a;
      b_d = b;
      ctrl_d = alu_ctrl;
      idx_d = '0;
      carry_d = alu_ctrl[2];
      state_d = RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == RUN) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      sh_d = sh_next;
      carry_d = s_cout;
      idx_d = idx_q + 1'b1;
      if (idx_q == IW'(WIDTH - 1)) begin
        state_d = DONE;
        result_d = fin;
        zero_d = fin == '0;
        ovf_d = ctrl_q[1] & ovf_bit;
        cout_d = ctrl_q[1] & s_cout;
      end
    end
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sh_q <= '0;
      ctrl_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
      result_q <= '0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sh_q <= sh_d;
      ctrl_q <= ctrl_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      result_q <= result_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
      cout_q <= cout_d;
    end
  end

  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign result = result_q;
  assign zero = zero_q;
  assign overflow = ovf_q;
  assign carry_out = cout_q;
endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed table, corner sequences and random ops against an arithmetic model
module tb_serial_alu;
  import alu_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] a = '0, b = '0, result;
  logic [3:0] alu_ctrl = '0;
  logic busy, done, zero, overflow, carry_out;
  int n_total = 0, n_pass = 0;

  typedef struct {
    logic [31:0] a, b;
    logic [3:0] c;
    logic [31:0] r;
    logic z, ov, co;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic z, ov, co;
  } exp_t;

  serial_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .alu_ctrl(alu_ctrl),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .overflow(overflow), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] c);
    exp_t m;
    logic [31:0] aa, bb;
    logic [32:0] u;
    longint s;
    aa = c[3] ? ~x : x;
    bb = c[2] ? ~y : y;
    u = {1'b0, aa} + {1'b0, bb} + 33'(c[2]);
    s = longint'($signed(aa)) + longint'($signed(bb)) + longint'(c[2]);
    case (c[1:0])
      2'd0: m.r = aa & bb;
      2'd1: m.r = aa | bb;
      2'd2: m.r = u[31:0];
      default: m.r = {31'b0, s < 0};
    endcase
    m.z = m.r == 0;
    m.ov = c[1] && (s > 64'sd2147483647 || s < -64'sd2147483648);
    m.co = c[1] && u[32];
    return m;
  endfunction

  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] ic, output int lat);
    @(negedge clk);
    a = ia;
    b = ib;
    alu_ctrl = ic;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic check_out(input string name, input logic [31:0] r, input logic z, input logic ov, input logic co);
    check({name, ".result"}, result, r);
    check({name, ".zero"}, zero, z);
    check({name, ".overflow"}, overflow, ov);
    check({name, ".carry_out"}, carry_out, co);
  endtask

  initial begin
    vec_t tbl[9];
    exp_t e;
    int lat, dones;
    logic [31:0] ra, rb;
    logic [3:0] rc;
    tbl[0] = '{32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'd7, 32'd7, ALU_SUB, 32'd0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h7FFFFFFF, 32'd1, ALU_ADD, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{32'hFFFFFFFF, 32'd1, ALU_SLT, 32'd1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{32'h7FFFFFFF, 32'h80000000, ALU_SLT, 32'd0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{32'h0F0F0F0F, 32'h00FF00FF, ALU_NOR, 32'hF000F000, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'h0F0F0F0F, 32'h00FF00FF, ALU_OR, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'h0F0F0F0F, 32'h00FF00FF, ALU_AND, 32'h000F000F, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{32'hFFFFFFFF, 32'd1, ALU_ADD, 32'd0, 1'b1, 1'b0, 1'b1};

    #12;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check_out("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].c, lat);
      check($sformatf("vec%0d.latency", i), lat, 33);
      check_out($sformatf("vec%0d", i), tbl[i].r, tbl[i].z, tbl[i].ov, tbl[i].co);
      @(posedge clk);
      #1 check($sformatf("vec%0d.done_pulse", i), done, 0);
      check_out($sformatf("vec%0d.hold", i), tbl[i].r, tbl[i].z, tbl[i].ov, tbl[i].co);
    end

    // start pulses during RUN are ignored: exactly one done
    @(negedge clk);
    a = 32'd100; b = 32'd23; alu_ctrl = ALU_SUB; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignore.busy", busy, 1);
    dones = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      start = (k == 5 || k == 20) ? 1'b1 : 1'b0;
      a = 32'd1; b = 32'd1; alu_ctrl = ALU_ADD;
      if (done) dones++;
    end
    start = 1'b0;
    check("ignore.done_count", dones, 1);
    check("ignore.result", result, 32'd77);

    // start held through DONE: back-to-back operation
    @(negedge clk);
    a = 32'd3; b = 32'd4; alu_ctrl = ALU_ADD; start = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 while (!done && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check("b2b.first_latency", lat, 33);
    check("b2b.first_result", result, 32'd7);
    a = 32'h12345678; b = 32'h11111111; alu_ctrl = ALU_SUB;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    check("b2b.busy_again", busy, 1);
    while (!done && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check("b2b.second_period", lat, 33);
    check_out("b2b.second", 32'h01234567, 0, 0, 1);

    // asynchronous reset mid-RUN
    @(negedge clk);
    a = 32'd9; b = 32'd9; alu_ctrl = ALU_ADD; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset.busy", busy, 0);
    check("midreset.done", done, 0);
    check_out("midreset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd1, 32'd1, ALU_ADD, lat);
    check("post_reset.latency", lat, 33);
    check_out("post_reset", 32'd2, 0, 0, 0);

    // random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      rc = 4'($urandom_range(0, 15));
      e = model(ra, rb, rc);
      run_op(ra, rb, rc, lat);
      check($sformatf("rand%0d.latency", i), lat, 33);
      check_out($sformatf("rand%0d", i), e.r, e.z, e.ov, e.co);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/serial_alu.md
# serial_alu

Bit-serial 32-bit MIPS ALU that drives one instance of the team's 1-bit ALU slice over WIDTH consecutive cycles, with a registered carry between bits. It is the control-and-datapath wrapper placed directly upstream of the slice. It accepts full-width operands plus a 4-bit ALU control code and returns a full-width result with zero, overflow and carry flags. It targets the area-reduced datapath variant, where a multi-cycle ALU is acceptable.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 2
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  request; sampled only in IDLE or DONE
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- alu_ctrl  in  4  {a_invert, b_invert, operation[1:0]}; sampled with start
- busy  out  1  high during RUN
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  result; held until the next accepted start
- zero  out  1  result == 0; held with result
- overflow  out  1  signed overflow for add/sub/slt, else 0
- carry_out  out  1  carry out of the MSB slice, else 0 for AND/OR

## Operation
- Codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100. Other codes decode field-by-field with the same rules.
- Reset: state IDLE; busy, done, result, zero, overflow and carry_out all 0.
- IDLE:
  - start=1 latches a, b and alu_ctrl into shift registers.
  - Clears bit index to 0.
  - Loads the carry flop with b_invert, so subtract gets +1.
  - Goes to RUN.
- RUN, each cycle i = 0..WIDTH-1:
  - Slice inputs: a_q[0], b_q[0], the carry flop, less=0, a_invert, b_invert.
  - Slice operation: the latched operation, except 11 (SLT), which is forced to 10 (add).
  - Slice result shifts into the MSB of result_sh. a_q and b_q shift right. Carry flop takes the slice carry_out.
  - At i = WIDTH-1, record c_msb_in (carry into the MSB), c_msb_out and sum_msb. Go to DONE.
- DONE, exactly one cycle:
  - done=1.
  - result = result_sh for op 00/01/10. For SLT, result = {0…, sum_msb ^ (c_msb_in ^ c_msb_out)}.
  - overflow = c_msb_in ^ c_msb_out when op is 10 or 11, else 0.
  - carry_out = c_msb_out when op is 10 or 11, else 0.
  - zero computed from the final result.
  - Next state: RUN if start=1 (back-to-back, latched as in IDLE), else IDLE.
- start during RUN is ignored; there is no queueing.
- result, zero, overflow and carry_out update only at entry to DONE and are stable otherwise.

## Timing
- Start accepted at edge E0. busy=1 from E0 to E0+WIDTH.
- done=1 in the cycle after edge E0+WIDTH; latency is WIDTH+1 cycles (33 at default).
- Throughput with back-to-back starts: one operation per WIDTH+1 cycles.
- rst_n low at any time, including mid-RUN: immediate return to IDLE with all outputs 0. The first start after release is accepted on the first edge with rst_n high.
- No combinational path from inputs to outputs.

## Structure
- Shared package alu_pkg:
  - ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR (4-bit)
  - state type {IDLE, RUN, DONE}
  - OP_AND..OP_SLT (2-bit)
- Sub-module: one instance of the existing 1-bit slice bit_alu.
- Everything else (FSM, index counter, shift registers, carry flop, flag logic) lives in serial_alu.

## Test plan
- ADD a=5, b=7 -> done exactly 33 cycles after start; result 12, zero 0, overflow 0, carry_out 0.
- SUB a=7, b=7 -> result 0, zero 1, carry_out 1, overflow 0. ADD 0x7FFFFFFF+1 -> 0x80000000, overflow 1.
- SLT a=0xFFFFFFFF, b=1 -> result 1. SLT a=0x7FFFFFFF, b=0x80000000 -> result 0 (overflow-corrected), overflow 1.
- NOR a=0x0F0F0F0F, b=0x00FF00FF -> 0xF000F000, carry_out 0. OR same operands -> 0x0FFF0FFF.
- start pulses during RUN -> ignored, exactly one done. start held high through DONE -> next operation begins, second done 33 cycles later.
- rst_n low mid-RUN (bit 10) -> busy, done and result go 0 immediately. After release, ADD 1+1 -> 2 with normal latency.
